shift_deserializer: RTL and testbench
=====================================

# shift_deserializer

Serial-to-parallel receiver that reassembles WIDTH-bit words from a one-bit stream produced by the universal shift register in serial-shift mode. It accepts bits under a valid/ready handshake, supports both shift directions (MSB-first and LSB-first), and holds one completed word in an output buffer drained by a valid/ready consumer. It sits at the receiving end of a serial link, between the bit source and the parallel datapath.

## Interface
- WIDTH, 4, word length in bits; legal range 2..16.
- clk  in  1  rising-edge clock.
- rst  in  1  reset: one clock, synchronous, active-high.
- s_valid  in  1  the bit on s_bit is offered this cycle.
- s_bit  in  1  serial data bit.
- s_first  in  1  qualifies s_bit as bit 0 of a new word; sampled only when s_valid=1.
- s_dir  in  1  sampled only with an accepted s_first bit. 0 = MSB-first, bits shift in at the LSB (shift-left). 1 = LSB-first, bits shift in at the MSB (shift-right).
- s_ready  out  1  block accepts a bit this cycle.
- q  out  WIDTH  assembled word.
- q_valid  out  1  q holds an unconsumed word.
- q_ready  in  1  consumer takes q this cycle.
- err  out  1  one-cycle pulse on a framing event.

## Operation
- A bit is accepted when s_valid && s_ready.
- States:
  - IDLE: s_ready=1. An accepted bit with s_first=1 loads bit 0, latches s_dir, sets cnt=1 and moves to SHIFT. An accepted bit with s_first=0 is dropped and pulses err; state stays IDLE.
  - SHIFT: s_ready=1. Each accepted bit with s_first=0 shifts into sr per the latched direction and increments cnt. On the accepted bit that makes cnt=WIDTH, the word is complete:
    - if q_valid=0, or q_valid && q_ready in that cycle, the word is copied to q, q_valid is 1 next cycle, and the state returns to IDLE;
    - otherwise the state moves to FULL.
  - FULL: s_ready=0. On q_valid && q_ready, sr is copied to q, q_valid stays 1, and the state moves to IDLE.
- Abort: an accepted s_first=1 bit in SHIFT discards the partial word, restarts with that bit as bit 0, relatches s_dir, sets cnt=1 and pulses err.
- Consumption: q_valid && q_ready with no word arriving in the same cycle clears q_valid next cycle.
- Width rules:
  - sr is WIDTH bits; cnt is $clog2(WIDTH+1) bits and never exceeds WIDTH.
  - MSB-first update: sr <= {sr[WIDTH-2:0], s_bit}.
  - LSB-first update: sr <= {s_bit, sr[WIDTH-1:1]}.
- Output behaviour: q is stable while q_valid=1 and q_ready=0.

## Timing
- Reset (rst=1 at a rising edge): state=IDLE, sr=0, cnt=0, q=0, q_valid=0, err=0. s_ready is 1 in the cycle after reset.
- Reset mid-word or in FULL discards all partial and pending data, including a valid q.
- Latency: the last bit is accepted at edge N, and q_valid=1 with the new q from the cycle after edge N.
- Throughput: with q_ready held at 1, one word every WIDTH cycles, with no bubble between words.
- s_ready is a function of the state only; there is no combinational path from q_ready or s_valid to s_ready.
- Back-pressure: s_ready returns to 1 the cycle after the FULL drain handshake.
- err is registered; it is high for exactly one cycle following the offending accepted bit.

## Structure
- Package shift_pkg holds:
  - the state typedef (IDLE, SHIFT, FULL);
  - direction constants DIR_MSB_FIRST=1'b0 and DIR_LSB_FIRST=1'b1.
- The block is a single module, with no sub-module. The FSM, counter, shift register and output buffer are small enough to stay flat.

## Test plan
All scenarios use WIDTH=4.
- MSB-first, q_ready=1: bits 1,0,1,0 with s_first on the first bit and s_dir=0 -> q=4'b1010 and q_valid for one cycle, 1 cycle after the 4th bit; err stays 0.
- LSB-first: bits 0,1,0,1 with s_dir=1 -> q=4'b1010; a back-to-back second word 1,1,0,0 -> q=4'b0011 exactly 4 cycles later.
- Back-pressure with q_ready=0:
  - first word 4'b1100 -> q_valid=1;
  - second word 4'b0110 -> FULL, s_ready=0, and q stays 4'b1100;
  - q_ready pulse -> q=4'b0110 the next cycle, and s_ready=1 the cycle after the handshake.
- Abort: bits 1,1 and then an s_first bit 0 followed by 1,0,1 -> err pulse after the 3rd accepted bit, then q=4'b0101.
- Stray bits: s_valid bits with s_first=0 while in IDLE -> one err pulse per bit, no state change and q_valid=0.
- Reset mid-word: rst after 2 bits -> q=0, q_valid=0 and cnt=0; a following full word 4'b1001 is received correctly.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the serial-to-parallel receiver: FSM states and shift-direction encodings.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deserializer.sv
// Reassembles WIDTH-bit words from a framed one-bit stream (MSB- or LSB-first)
// and holds one completed word in a valid/ready output buffer.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic             s_bit,
    input  logic             s_first,
    input  logic             s_dir,
    output logic             s_ready,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] q_n;
    logic             q_valid_n;
    logic             err_n;
    logic             dir, dir_n;

    logic             accept;
    logic             drain;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] sr_load;
    logic [CW-1:0]    cnt_inc;

    // s_ready depends on state alone, so there is no path from q_ready or s_valid.
    assign s_ready = (state != FULL);
    assign accept  = s_valid && s_ready;
    assign drain   = q_valid && q_ready;
    assign cnt_inc = cnt + 1'b1;

    assign sr_shift = (dir == DIR_LSB_FIRST) ? {s_bit, sr[WIDTH-1:1]}
                                             : {sr[WIDTH-2:0], s_bit};
    // Bit 0 lands where the chosen direction will walk it to its final position.
    assign sr_load  = (s_dir == DIR_LSB_FIRST) ? {s_bit, {(WIDTH-1){1'b0}}}
                                               : {{(WIDTH-1){1'b0}}, s_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            err     <= 1'b0;
            dir     <= DIR_MSB_FIRST;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            cnt     <= cnt_n;
            q       <= q_n;
            q_valid <= q_valid_n;
            err     <= err_n;
            dir     <= dir_n;
        end
    end

    always_comb begin
        state_n   = state;
        sr_n      = sr;
        cnt_n     = cnt;
        q_n       = q;
        q_valid_n = drain ? 1'b0 : q_valid;
        err_n     = 1'b0;
        dir_n     = dir;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (s_first) begin
                        sr_n    = sr_load;
                        dir_n   = s_dir;
                        cnt_n   = CW'(1);
                        state_n = SHIFT;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (accept) begin
                    if (s_first) begin
                        sr_n  = sr_load;
                        dir_n = s_dir;
                        cnt_n = CW'(1);
                        err_n = 1'b1;
                    end else begin
                        sr_n  = sr_shift;
                        cnt_n = cnt_inc;
                        if (cnt_inc == CW'(WIDTH)) begin
                            if (!q_valid || q_ready) begin
                                q_n       = sr_shift;
                                q_valid_n = 1'b1;
                                cnt_n     = '0;
                                state_n   = IDLE;
                            end else begin
                                state_n = FULL;
                            end
                        end
                    end
                end
            end
            FULL: begin
                if (drain) begin
                    q_n       = sr;
                    q_valid_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed test of shift_deserializer with WIDTH=4: framing, both directions,
// back-pressure, abort, stray bits and mid-word reset.
module tb_shift_deserializer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_bit;
    logic             s_first;
    logic             s_dir;
    logic             s_ready;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_ready;
    logic             err;

    int checks = 0;
    int errors = 0;

    shift_deserializer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_bit   (s_bit),
        .s_first (s_first),
        .s_dir   (s_dir),
        .s_ready (s_ready),
        .q       (q),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one bit for one edge, then sample outputs 1ns after that edge.
    task automatic send_bit(input logic b, input logic first, input logic dir);
        @(negedge clk);
        s_valid = 1'b1;
        s_bit   = b;
        s_first = first;
        s_dir   = dir;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (q !== 4'b0000 || q_valid !== 1'b0 || err !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: q=%b q_valid=%b err=%b s_ready=%b, want 0000 0 0 1", q, q_valid, err, s_ready);
        end
    endtask

    task automatic test_msb_first();
        logic [3:0] bits;
        bits = 4'b1010;
        q_ready = 1'b1;
        for (int i = 3; i >= 1; i--) send_bit(bits[i], i == 3, 1'b0);
        checks++;
        if (q_valid !== 1'b0) begin
            errors++;
            $display("FAIL msb_early: q_valid=%b after 3 bits, want 0", q_valid);
        end
        send_bit(bits[0], 1'b0, 1'b0);
        checks++;
        if (q_valid !== 1'b1 || q !== 4'b1010 || err !== 1'b0) begin
            errors++;
            $display("FAIL msb_word: q=%b q_valid=%b err=%b, want 1010 1 0", q, q_valid, err);
        end
        idle_cycle();
        checks++;
        if (q_valid !== 1'b0) begin
            errors++;
            $display("FAIL msb_drain: q_valid=%b, want 0", q_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w1, w2;
        w1 = 4'b1010;  // sent LSB-first: 0,1,0,1
        w2 = 4'b0011;  // sent LSB-first: 1,1,0,0
        q_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(w1[i], i == 0, 1'b1);
        checks++;
        if (q_valid !== 1'b1 || q !== 4'b1010) begin
            errors++;
            $display("FAIL lsb_word1: q=%b q_valid=%b, want 1010 1", q, q_valid);
        end
        for (int i = 0; i < 4; i++) begin
            send_bit(w2[i], i == 0, 1'b1);
            if (i < 3) begin
                checks++;
                if (s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready: s_ready=%b at bit %0d, want 1", s_ready, i);
                end
            end
        end
        checks++;
        if (q_valid !== 1'b1 || q !== 4'b0011) begin
            errors++;
            $display("FAIL lsb_word2: q=%b q_valid=%b, want 0011 1", q, q_valid);
        end
        idle_cycle();
    endtask

    task automatic test_backpressure();
        logic [3:0] w1, w2;
        w1 = 4'b1100;
        w2 = 4'b0110;
        q_ready = 1'b0;
        for (int i = 3; i >= 0; i--) send_bit(w1[i], i == 3, 1'b0);
        checks++;
        if (q_valid !== 1'b1 || q !== 4'b1100) begin
            errors++;
            $display("FAIL bp_word1: q=%b q_valid=%b, want 1100 1", q, q_valid);
        end
        for (int i = 3; i >= 0; i--) send_bit(w2[i], i == 3, 1'b0);
        checks++;
        if (s_ready !== 1'b0 || q !== 4'b1100 || q_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: s_ready=%b q=%b q_valid=%b, want 0 1100 1", s_ready, q, q_valid);
        end
        idle_cycle();
        checks++;
        if (s_ready !== 1'b0 || q !== 4'b1100) begin
            errors++;
            $display("FAIL bp_hold: s_ready=%b q=%b, want 0 1100", s_ready, q);
        end
        @(negedge clk);
        q_ready = 1'b1;
        @(posedge clk);
        #1;
        q_ready = 1'b0;
        checks++;
        if (q !== 4'b0110 || q_valid !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: q=%b q_valid=%b s_ready=%b, want 0110 1 1", q, q_valid, s_ready);
        end
        @(negedge clk);
        q_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (q_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: q_valid=%b, want 0", q_valid);
        end
    endtask

    task automatic test_abort();
        q_ready = 1'b1;
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        checks++;
        if (err !== 1'b1 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_err: err=%b q_valid=%b, want 1 0", err, q_valid);
        end
        send_bit(1'b1, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse: err=%b, want 0", err);
        end
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        checks++;
        if (q_valid !== 1'b1 || q !== 4'b0101) begin
            errors++;
            $display("FAIL abort_word: q=%b q_valid=%b, want 0101 1", q, q_valid);
        end
        idle_cycle();
    endtask

    task automatic test_stray();
        q_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_bit(i[0], 1'b0, 1'b0);
            checks++;
            if (err !== 1'b1 || q_valid !== 1'b0 || s_ready !== 1'b1) begin
                errors++;
                $display("FAIL stray_%0d: err=%b q_valid=%b s_ready=%b, want 1 0 1", i, err, q_valid, s_ready);
            end
        end
        idle_cycle();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL stray_end: err=%b, want 0", err);
        end
    endtask

    task automatic test_reset_midword();
        logic [3:0] w;
        w = 4'b1001;
        q_ready = 1'b0;
        for (int i = 3; i >= 0; i--) send_bit(w[i], i == 3, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        do_reset();
        checks++;
        if (q !== 4'b0000 || q_valid !== 1'b0 || dut.cnt !== '0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: q=%b q_valid=%b cnt=%0d s_ready=%b, want 0000 0 0 1", q, q_valid, dut.cnt, s_ready);
        end
        q_ready = 1'b1;
        for (int i = 3; i >= 0; i--) send_bit(w[i], i == 3, 1'b0);
        checks++;
        if (q_valid !== 1'b1 || q !== 4'b1001 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_word: q=%b q_valid=%b err=%b, want 1001 1 0", q, q_valid, err);
        end
        idle_cycle();
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_bit   = 1'b0;
        s_first = 1'b0;
        s_dir   = 1'b0;
        q_ready = 1'b0;
        test_reset();
        test_msb_first();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_stray();
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
